// File: rtl/multi_clock_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_clock_monitor: sampled checker for the instr/mem two-phase pair.   |
// | Optional stats build macro: MULTI_CLOCK_MON_STATS_EN.       Rev 1.0      |
// +--------------------------------------------------------------------------+
module multi_clock_monitor #(
  parameter int CNT_W       = 16,
  parameter int TIMEOUT     = 1000,
  parameter int MIN_WIDTH   = 2,
  parameter int LOCK_CYCLES = 4
) (
  input  logic             clock,
  input  logic             reset_bar,
  input  logic             instr_clk_in,
  input  logic             mem_clk_in,
  input  logic             err_clear,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] cycle_count,
  output logic             locked,
  output logic             overlap_err,
  output logic             order_err,
  output logic             timeout_err,
  output logic             width_err,
  output logic [CNT_W-1:0] min_hi_w,
  output logic [CNT_W-1:0] max_hi_w
);
  localparam int LK_W = $clog2(LOCK_CYCLES + 1);

  typedef enum logic [1:0] {
    INSTR_HI   = 2'd0,
    WAIT_MEM   = 2'd1,
    MEM_HI     = 2'd2,
    WAIT_INSTR = 2'd3
  } phase_e;

  phase_e           state_q, state_d;
  logic [1:0]       instr_sync_q, mem_sync_q;
  logic             instr_dly_q, mem_dly_q;
  logic             first_q;
  logic [CNT_W-1:0] cycle_q, cycle_d, state_cnt_q, state_cnt_d;
  logic [CNT_W-1:0] ihi_q, ihi_d, mhi_q, mhi_d;
  logic [3:0]       err_q, err_d, det;  // {width, timeout, order, overlap}
  logic [LK_W-1:0]  lock_q, lock_d;
  logic             clean_q, clean_d;

  logic       i_s, m_s, i_rise, i_fall, m_rise, m_fall;
  logic [3:0] edges, used;
  logic [1:0] cur, st1, st2;
  logic       legal1, legal2, cycle_evt;

  assign i_s    = instr_sync_q[1];
  assign m_s    = mem_sync_q[1];
  assign i_rise = i_s & ~instr_dly_q;
  assign i_fall = ~i_s & instr_dly_q;
  assign m_rise = m_s & ~mem_dly_q;
  assign m_fall = ~m_s & mem_dly_q;

  // Bit n is the edge that legally leaves phase n. The instr line is held high
  // through reset, so its first synced rise while still in INSTR_HI is benign.
  assign edges = {i_rise & ~(first_q & (state_q == INSTR_HI)), m_fall, m_rise, i_fall};

  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) state_q <= INSTR_HI;
    else            state_q <= state_d;
  end

  always_comb begin
    cur    = state_q;
    used   = '0;
    legal1 = edges[cur];
    st1    = legal1 ? cur + 2'd1 : cur;
    if (legal1) used[cur] = 1'b1;
    // A hand-off (e.g. instr fall with mem rise) can land in one sample clock.
    legal2 = legal1 & edges[st1];
    st2    = legal2 ? st1 + 2'd1 : st1;
    if (legal2) used[st1] = 1'b1;

    det[0] = i_s & m_s;
    det[1] = |(edges & ~used);

    state_d   = state_q;
    cycle_evt = 1'b0;
    if (det[0]) begin
      state_d = state_q;
    end else if (det[1]) begin
      if (i_s)         state_d = INSTR_HI;
      else if (m_s)    state_d = MEM_HI;
      else if (i_fall) state_d = WAIT_MEM;
      else if (m_fall) state_d = WAIT_INSTR;
    end else begin
      state_d   = phase_e'(st2);
      cycle_evt = (legal1 && state_q == WAIT_INSTR) ||
                  (legal2 && phase_e'(st1) == WAIT_INSTR);
    end

    state_cnt_d = (state_d != state_q) ? '0 :
                  (&state_cnt_q) ? state_cnt_q : state_cnt_q + CNT_W'(1);
    det[2] = (state_d == state_q) && (state_cnt_q == CNT_W'(TIMEOUT - 1));

    ihi_d  = i_s ? ((&ihi_q) ? ihi_q : ihi_q + CNT_W'(1)) : '0;
    mhi_d  = m_s ? ((&mhi_q) ? mhi_q : mhi_q + CNT_W'(1)) : '0;
    det[3] = (i_fall && ihi_q < CNT_W'(MIN_WIDTH)) ||
             (m_fall && mhi_q < CNT_W'(MIN_WIDTH));

    err_d   = (err_q & {4{~err_clear}}) | det;
    cycle_d = cycle_evt ? cycle_q + CNT_W'(1) : cycle_q;

    lock_d  = lock_q;
    clean_d = clean_q;
    if (|det) begin
      lock_d  = '0;
      clean_d = 1'b0;
    end else if (err_clear) begin
      lock_d  = '0;
      clean_d = 1'b1;
    end else if (cycle_evt) begin
      if (clean_q && lock_q != LK_W'(LOCK_CYCLES)) lock_d = lock_q + LK_W'(1);
      clean_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) begin
      instr_sync_q <= '0;
      mem_sync_q   <= '0;
      instr_dly_q  <= 1'b0;
      mem_dly_q    <= 1'b0;
      first_q      <= 1'b1;
      cycle_q      <= '0;
      state_cnt_q  <= '0;
      ihi_q        <= '0;
      mhi_q        <= '0;
      err_q        <= '0;
      lock_q       <= '0;
      clean_q      <= 1'b1;
    end else begin
      instr_sync_q <= {instr_sync_q[0], instr_clk_in};
      mem_sync_q   <= {mem_sync_q[0], mem_clk_in};
      instr_dly_q  <= i_s;
      mem_dly_q    <= m_s;
      first_q      <= first_q & ~i_fall;
      cycle_q      <= cycle_d;
      state_cnt_q  <= state_cnt_d;
      ihi_q        <= ihi_d;
      mhi_q        <= mhi_d;
      err_q        <= err_d;
      lock_q       <= lock_d;
      clean_q      <= clean_d;
    end
  end

  assign phase       = state_q;
  assign cycle_count = cycle_q;
  assign locked      = (lock_q == LK_W'(LOCK_CYCLES));
  assign overlap_err = err_q[0];
  assign order_err   = err_q[1];
  assign timeout_err = err_q[2];
  assign width_err   = err_q[3];

`ifdef MULTI_CLOCK_MON_STATS_EN
  logic [CNT_W-1:0] min_q, max_q;

  always_ff @(posedge clock or negedge reset_bar) begin
    if (!reset_bar) begin
      min_q <= '1;
      max_q <= '0;
    end else if (err_clear) begin
      min_q <= '1;
      max_q <= '0;
    end else if (i_fall && !first_q) begin
      if (ihi_q < min_q) min_q <= ihi_q;
      if (ihi_q > max_q) max_q <= ihi_q;
    end
  end

  assign min_hi_w = min_q;
  assign max_hi_w = max_q;
`else
  assign min_hi_w = '0;
  assign max_hi_w = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_clock_monitor.sv
`default_nettype none
// Testbench for multi_clock_monitor: directed and randomized phase waveforms
// checked against a waveform-level model of the expected monitor status.
module tb_multi_clock_monitor;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             reset_bar = 1'b1;
  logic             instr_clk_in = 1'b1;
  logic             mem_clk_in = 1'b0;
  logic             err_clear = 1'b0;
  logic [1:0]       phase;
  logic [CNT_W-1:0] cycle_count, min_hi_w, max_hi_w;
  logic             locked, overlap_err, order_err, timeout_err, width_err;

  int checks = 0;
  int errors = 0;

  // model state: what the monitor should report given the driven waveform
  int exp_count;
  int hi_len;
  bit instr_lvl;
  bit first_fall;
  int exp_min, exp_max;

  always #5 clock = ~clock;

  multi_clock_monitor dut (
    .clock(clock), .reset_bar(reset_bar), .instr_clk_in(instr_clk_in),
    .mem_clk_in(mem_clk_in), .err_clear(err_clear), .phase(phase),
    .cycle_count(cycle_count), .locked(locked), .overlap_err(overlap_err),
    .order_err(order_err), .timeout_err(timeout_err), .width_err(width_err),
    .min_hi_w(min_hi_w), .max_hi_w(max_hi_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold the given levels for n sample clocks; instr-high widths are recorded
  // in sample clocks at each instr fall (the first after reset is not a stat).
  task automatic drive(input bit i, input bit m, input int n);
    if (instr_lvl && !i) begin
      if (!first_fall) begin
        if (hi_len < exp_min) exp_min = hi_len;
        if (hi_len > exp_max) exp_max = hi_len;
      end
      first_fall = 1'b0;
      hi_len     = 0;
    end
    instr_clk_in = i;
    mem_clk_in   = m;
    instr_lvl    = i;
    for (int k = 0; k < n; k++) begin
      tick();
      if (i) hi_len++;
    end
  endtask

  task automatic check_stats(input string tag);
`ifdef MULTI_CLOCK_MON_STATS_EN
    chk({tag, "_min"}, min_hi_w, exp_min);
    chk({tag, "_max"}, max_hi_w, exp_max);
`else
    chk({tag, "_min"}, min_hi_w, 0);
    chk({tag, "_max"}, max_hi_w, 0);
`endif
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_phase"}, phase, 0);
    chk({tag, "_count"}, cycle_count, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_errs"}, {width_err, timeout_err, order_err, overlap_err}, 0);
    check_stats(tag);
  endtask

  task automatic do_reset();
    instr_clk_in = 1'b1;
    mem_clk_in   = 1'b0;
    err_clear    = 1'b0;
    instr_lvl    = 1'b1;
    hi_len       = 0;
    first_fall   = 1'b1;
    exp_min      = (1 << CNT_W) - 1;
    exp_max      = 0;
    exp_count    = 0;
    reset_bar    = 1'b0;
    #13;
    check_reset_vals("rst");
    tick();
    reset_bar = 1'b1;
  endtask

  task automatic clear_pulse();
    err_clear = 1'b1;
    tick();
    err_clear = 1'b0;
    exp_min   = (1 << CNT_W) - 1;
    exp_max   = 0;
  endtask

  // One legal cycle starting with instr high: fall, gap, mem pulse, gap, rise.
  task automatic cycle(input int hi_extra, input int g1, input int mh, input int g2);
    drive(0, 0, g1);
    drive(0, 1, 4);
    chk("cyc_mem_phase", phase, 2);
    drive(0, 1, mh - 4);
    drive(0, 0, g2);
    drive(1, 0, 4);
    exp_count++;
    chk("cyc_count", cycle_count, exp_count);
    chk("cyc_instr_phase", phase, 0);
    drive(1, 0, hi_extra);
  endtask

  initial begin
    #2;
    // ideal pair: period 20, 10 high each, zero-gap hand-offs
    do_reset();
    drive(1, 0, 10);
    for (int c = 0; c < 10; c++) cycle(6, 0, 10, 0);
    chk("t1_count", cycle_count, 10);
    chk("t1_locked", locked, 1);
    chk("t1_errs", {width_err, timeout_err, order_err, overlap_err}, 0);
    check_stats("t1");

    // overlap: mem forced high during instr high
    drive(1, 1, 3);
    drive(1, 0, 5);
    chk("t2_overlap", overlap_err, 1);
    chk("t2_locked", locked, 0);
    chk("t2_phase", phase, 0);
    chk("t2_count", cycle_count, exp_count);
    clear_pulse();
    chk("t2_clr_errs", {width_err, timeout_err, order_err, overlap_err}, 0);
    for (int c = 0; c < 3; c++) cycle(2, 1, 6, 1);
    chk("t2_lock3", locked, 0);
    cycle(2, 1, 6, 1);
    chk("t2_lock4", locked, 1);

    // dropped mem pulse
    drive(0, 0, 6);
    drive(1, 0, 6);
    chk("t3_order", order_err, 1);
    chk("t3_phase", phase, 0);
    chk("t3_locked", locked, 0);
    chk("t3_count", cycle_count, exp_count);
    clear_pulse();
    chk("t3_clr", order_err, 0);

    // one-clock mem glitch
    drive(0, 0, 3);
    drive(0, 1, 1);
    drive(0, 0, 5);
    chk("t5_width", width_err, 1);
    chk("t5_order", order_err, 0);
    chk("t5_phase", phase, 3);
    drive(1, 0, 6);
    exp_count++;
    chk("t5_count", cycle_count, exp_count);
    clear_pulse();
    chk("t5_clr", width_err, 0);

    // randomized legal cycles
    clear_pulse();
    for (int c = 0; c < 12; c++)
      cycle($urandom_range(0, 8), $urandom_range(0, 3), $urandom_range(4, 12),
            $urandom_range(0, 3));
    chk("rnd_errs", {width_err, timeout_err, order_err, overlap_err}, 0);
    chk("rnd_locked", locked, 1);
    check_stats("rnd");

    // stall: instr held high after reset release
    do_reset();
    drive(1, 0, 999);
    chk("t4_before", timeout_err, 0);
    drive(1, 0, 1);
    chk("t4_at", timeout_err, 1);
    chk("t4_others", {width_err, order_err, overlap_err}, 0);
    clear_pulse();
    drive(1, 0, 500);
    chk("t4_once", timeout_err, 0);

    // reset asserted mid MEM_HI
    cycle(2, 1, 6, 1);
    drive(0, 0, 3);
    drive(0, 1, 5);
    chk("t6_phase", phase, 2);
    #3;
    reset_bar = 1'b0;
    exp_min   = (1 << CNT_W) - 1;
    exp_max   = 0;
    #1;
    check_reset_vals("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
